// File: rtl/l2_tcdm_interleaved_xbar_if.sv
// l2_tcdm_interleaved_xbar_if: TCDM master-side requests/responses and L2 bank-side drive of the crossbar
interface l2_tcdm_interleaved_xbar_if #(
  parameter int NB_MASTERS      = 6,
  parameter int NB_BANKS        = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 15
);
  logic [NB_MASTERS-1:0]                 mst_req_i;
  logic [NB_MASTERS*ADDR_WIDTH-1:0]      mst_add_i;
  logic [NB_MASTERS-1:0]                 mst_wen_i;
  logic [NB_MASTERS*DATA_WIDTH-1:0]      mst_wdata_i;
  logic [NB_MASTERS*DATA_WIDTH/8-1:0]    mst_be_i;
  logic [NB_MASTERS-1:0]                 mst_gnt_o;
  logic [NB_MASTERS-1:0]                 mst_r_valid_o;
  logic [NB_MASTERS*DATA_WIDTH-1:0]      mst_r_rdata_o;
  logic [NB_BANKS-1:0]                   bank_req_o;
  logic [NB_BANKS*BANK_ADDR_WIDTH-1:0]   bank_add_o;
  logic [NB_BANKS-1:0]                   bank_wen_o;
  logic [NB_BANKS*DATA_WIDTH-1:0]        bank_wdata_o;
  logic [NB_BANKS*DATA_WIDTH/8-1:0]      bank_be_o;
  logic [NB_BANKS*DATA_WIDTH-1:0]        bank_rdata_i;
  modport slave (
    input  mst_req_i, mst_add_i, mst_wen_i, mst_wdata_i, mst_be_i, bank_rdata_i,
    output mst_gnt_o, mst_r_valid_o, mst_r_rdata_o,
           bank_req_o, bank_add_o, bank_wen_o, bank_wdata_o, bank_be_o
  );
  modport master (
    output mst_req_i, mst_add_i, mst_wen_i, mst_wdata_i, mst_be_i, bank_rdata_i,
    input  mst_gnt_o, mst_r_valid_o, mst_r_rdata_o,
           bank_req_o, bank_add_o, bank_wen_o, bank_wdata_o, bank_be_o
  );
endinterface

// File: rtl/l2_tcdm_interleaved_xbar.sv
// l2_tcdm_interleaved_xbar: word-interleaved TCDM-to-L2 crossbar with per-bank RR/fixed arbitration and registered response routing
module l2_tcdm_interleaved_xbar #(
  parameter int NB_MASTERS      = 6,
  parameter int NB_BANKS        = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 15,
  parameter int ARB_MODE        = 0
) (
  input logic clk_i,
  input logic rst_ni,
  l2_tcdm_interleaved_xbar_if.slave bus
);
  localparam int LB = $clog2(NB_BANKS);
  localparam int PW = NB_MASTERS > 1 ? $clog2(NB_MASTERS) : 1;
  localparam int BW = DATA_WIDTH / 8;
  logic [LB-1:0]              w_bank [NB_MASTERS];
  logic [BANK_ADDR_WIDTH-1:0] w_row  [NB_MASTERS];
  logic [NB_BANKS-1:0]        w_bvalid;
  logic [PW-1:0]              w_win  [NB_BANKS];
  logic [PW-1:0]              r_rr_q [NB_BANKS];
  logic [NB_MASTERS-1:0]      w_gnt;
  logic [NB_MASTERS-1:0]      r_pending_q;
  logic [LB-1:0]              r_bank_q [NB_MASTERS];
  logic                       w_unused;
  // byte offset and bits above the row field are dropped, so addresses wrap modulo L2 size
  assign w_unused = ^bus.mst_add_i;
  always_comb begin
    for (int m = 0; m < NB_MASTERS; m++) begin
      w_bank[m] = bus.mst_add_i[m*ADDR_WIDTH+2 +: LB];
      w_row[m]  = bus.mst_add_i[m*ADDR_WIDTH+2+LB +: BANK_ADDR_WIDTH];
    end
  end
  // scan downwards from the pointer so the first requester at/after it is the last one written
  always_comb begin
    int j;
    j = 0;
    w_bvalid = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      w_win[b] = '0;
      for (int k = NB_MASTERS-1; k >= 0; k--) begin
        j = (ARB_MODE == 0 ? int'(r_rr_q[b]) : 0) + k;
        j = j >= NB_MASTERS ? j - NB_MASTERS : j;
        if (bus.mst_req_i[j] && w_bank[j] == LB'(b)) begin
          w_bvalid[b] = 1'b1;
          w_win[b]    = PW'(j);
        end
      end
    end
  end
  always_comb begin
    for (int m = 0; m < NB_MASTERS; m++)
      w_gnt[m] = bus.mst_req_i[m] && w_bvalid[w_bank[m]] && w_win[w_bank[m]] == PW'(m);
  end
  assign bus.mst_gnt_o = w_gnt;
  always_comb begin
    for (int b = 0; b < NB_BANKS; b++) begin
      bus.bank_req_o[b] = w_bvalid[b];
      bus.bank_add_o[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = w_bvalid[b] ? w_row[w_win[b]] : '0;
      bus.bank_wen_o[b] = w_bvalid[b] ? bus.mst_wen_i[w_win[b]] : 1'b1;
      bus.bank_wdata_o[b*DATA_WIDTH +: DATA_WIDTH] = w_bvalid[b] ? bus.mst_wdata_i[w_win[b]*DATA_WIDTH +: DATA_WIDTH] : '0;
      bus.bank_be_o[b*BW +: BW] = w_bvalid[b] ? bus.mst_be_i[w_win[b]*BW +: BW] : '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending_q <= '0;
      for (int m = 0; m < NB_MASTERS; m++) r_bank_q[m] <= '0;
      for (int b = 0; b < NB_BANKS; b++) r_rr_q[b] <= '0;
    end else begin
      r_pending_q <= w_gnt;
      for (int m = 0; m < NB_MASTERS; m++) if (w_gnt[m]) r_bank_q[m] <= w_bank[m];
      for (int b = 0; b < NB_BANKS; b++)
        if (w_bvalid[b]) r_rr_q[b] <= w_win[b] == PW'(NB_MASTERS-1) ? '0 : w_win[b] + 1'b1;
    end
  end
  assign bus.mst_r_valid_o = r_pending_q;
  always_comb begin
    for (int m = 0; m < NB_MASTERS; m++)
      bus.mst_r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = r_pending_q[m] ? bus.bank_rdata_i[r_bank_q[m]*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
endmodule

// File: tb/tb_l2_tcdm_interleaved_xbar.sv
// tb_l2_tcdm_interleaved_xbar: directed vectors with a per-master response scoreboard for RR and fixed-priority crossbars
module tb_l2_tcdm_interleaved_xbar;
  localparam int NM = 6, NB = 8, BAW = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  int errors = 0, checks = 0;
  logic [32:0] sq [2][NM][$];
  logic        exp_wen [2][NM];
  logic [31:0] exp_rd  [2][NM];
  logic [31:0] mem [int];
  logic [NB*32-1:0] rd0 = '0, rd1 = '0;
  logic [32:0] mon_e;
  always #5 clk = ~clk;
  l2_tcdm_interleaved_xbar_if #(.NB_MASTERS(NM), .NB_BANKS(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BANK_ADDR_WIDTH(BAW)) bus0 ();
  l2_tcdm_interleaved_xbar_if #(.NB_MASTERS(NM), .NB_BANKS(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BANK_ADDR_WIDTH(BAW)) bus1 ();
  l2_tcdm_interleaved_xbar #(.NB_MASTERS(NM), .NB_BANKS(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BANK_ADDR_WIDTH(BAW), .ARB_MODE(0))
    dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
  l2_tcdm_interleaved_xbar #(.NB_MASTERS(NM), .NB_BANKS(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BANK_ADDR_WIDTH(BAW), .ARB_MODE(1))
    dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));
  assign bus0.bank_rdata_i = rd0;
  assign bus1.bank_rdata_i = rd1;
  function automatic int key(int d, int b, logic [BAW-1:0] row);
    return d * (1 << 20) + b * (1 << 15) + int'(row);
  endfunction
  function automatic logic [31:0] init(int k);
    if (k == key(0, 3, 0)) return 32'hDEAD_BEEF;
    if (k == key(0, 0, 1)) return 32'h2020_2020;
    if (k == key(0, 1, 15'h800)) return 32'h1122_3344;
    if (k == key(1, 2, 0)) return 32'hCAFE_0002;
    if (k >= 0 && k < key(0, NB, 0) && k % 32768 == 0) return 32'hB0B0_0000 | 32'(k / 32768);
    return 32'h0;
  endfunction
  function automatic logic [31:0] rdm(int k);
    return mem.exists(k) ? mem[k] : init(k);
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[i*8 +: 8] = n[i*8 +: 8];
    return o;
  endfunction
  // single-ported bank models: read data registered one cycle after the chip-select
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus0.bank_req_o[b] && bus0.bank_wen_o[b]) rd0[b*32 +: 32] <= rdm(key(0, b, bus0.bank_add_o[b*BAW +: BAW]));
      if (bus0.bank_req_o[b] && !bus0.bank_wen_o[b])
        mem[key(0, b, bus0.bank_add_o[b*BAW +: BAW])] = merge(rdm(key(0, b, bus0.bank_add_o[b*BAW +: BAW])), bus0.bank_wdata_o[b*32 +: 32], bus0.bank_be_o[b*4 +: 4]);
      if (bus1.bank_req_o[b] && bus1.bank_wen_o[b]) rd1[b*32 +: 32] <= rdm(key(1, b, bus1.bank_add_o[b*BAW +: BAW]));
      if (bus1.bank_req_o[b] && !bus1.bank_wen_o[b])
        mem[key(1, b, bus1.bank_add_o[b*BAW +: BAW])] = merge(rdm(key(1, b, bus1.bank_add_o[b*BAW +: BAW])), bus1.bank_wdata_o[b*32 +: 32], bus1.bank_be_o[b*4 +: 4]);
    end
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic set_m(int d, int m, logic req, logic [31:0] add, logic wen, logic [31:0] wd, logic [3:0] be, logic [31:0] exp);
    if (d == 0) begin
      bus0.mst_req_i[m] = req; bus0.mst_add_i[m*32 +: 32] = add; bus0.mst_wen_i[m] = wen;
      bus0.mst_wdata_i[m*32 +: 32] = wd; bus0.mst_be_i[m*4 +: 4] = be;
    end else begin
      bus1.mst_req_i[m] = req; bus1.mst_add_i[m*32 +: 32] = add; bus1.mst_wen_i[m] = wen;
      bus1.mst_wdata_i[m*32 +: 32] = wd; bus1.mst_be_i[m*4 +: 4] = be;
    end
    exp_wen[d][m] = wen;
    exp_rd[d][m] = exp;
  endtask
  task automatic idle(int d);
    for (int m = 0; m < NM; m++) set_m(d, m, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
  endtask
  task automatic expect_gnt(int d, logic [NM-1:0] exp);
    @(negedge clk);
    chk($sformatf("gnt%0d", d), d ? bus1.mst_gnt_o : bus0.mst_gnt_o, exp);
    for (int m = 0; m < NM; m++) if (exp[m]) sq[d][m].push_back({exp_wen[d][m], exp_rd[d][m]});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // monitor: every response pops its master's queue; reads are checked against the expected data
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < NM; m++)
        if (d ? bus1.mst_r_valid_o[m] : bus0.mst_r_valid_o[m]) begin
          if (sq[d][m].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid%0d_%0d: got unexpected response, expected none", d, m);
          end else begin
            mon_e = sq[d][m].pop_front();
            if (mon_e[32]) chk($sformatf("rdata%0d_%0d", d, m), d ? bus1.mst_r_rdata_o[m*32 +: 32] : bus0.mst_r_rdata_o[m*32 +: 32], mon_e[31:0]);
          end
        end
  end
  initial begin
    idle(0);
    idle(1);
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus0.mst_gnt_o, 0);
    chk("rst_rvalid", bus0.mst_r_valid_o, 0);
    chk("rst_rdata", |bus0.mst_r_rdata_o, 0);
    chk("rst_breq", bus0.bank_req_o, 0);
    chk("rst_bwen", bus0.bank_wen_o, 8'hFF);
    chk("rst_badd", |bus0.bank_add_o, 0);
    #2 rst_n = 1'b1;
    tick();
    set_m(0, 0, 1'b1, 32'h0000_000C, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF);
    expect_gnt(0, 6'b000001);
    chk("t1_breq", bus0.bank_req_o, 8'b0000_1000);
    chk("t1_badd", bus0.bank_add_o[3*BAW +: BAW], 0);
    tick();
    for (int m = 0; m < NM; m++) set_m(0, m, 1'b1, 32'(m * 4), 1'b1, 32'h0, 4'hF, m == 3 ? 32'hDEAD_BEEF : 32'hB0B0_0000 | 32'(m));
    expect_gnt(0, 6'b111111);
    tick();
    idle(0);
    set_m(0, 1, 1'b1, 32'h20, 1'b1, 32'h0, 4'hF, 32'h2020_2020);
    set_m(0, 4, 1'b1, 32'h20, 1'b1, 32'h0, 4'hF, 32'h2020_2020);
    expect_gnt(0, 6'b000010); tick();
    expect_gnt(0, 6'b010000); tick();
    expect_gnt(0, 6'b000010); tick();
    expect_gnt(0, 6'b010000); tick();
    set_m(0, 4, 1'b0, 32'h20, 1'b1, 32'h0, 4'hF, 32'h0);
    set_m(0, 5, 1'b1, 32'h20, 1'b1, 32'h0, 4'hF, 32'h2020_2020);
    expect_gnt(0, 6'b100000); tick();
    set_m(0, 5, 1'b0, 32'h20, 1'b1, 32'h0, 4'hF, 32'h0);
    set_m(0, 0, 1'b1, 32'h20, 1'b1, 32'h0, 4'hF, 32'h2020_2020);
    expect_gnt(0, 6'b000001); tick();
    set_m(0, 0, 1'b0, 32'h20, 1'b1, 32'h0, 4'hF, 32'h0);
    expect_gnt(0, 6'b000010); tick();
    idle(0);
    set_m(0, 3, 1'b1, 32'h0001_0004, 1'b0, 32'hA5A5_A5A5, 4'b0011, 32'h0);
    expect_gnt(0, 6'b001000);
    chk("t5_bbe", bus0.bank_be_o[1*4 +: 4], 4'b0011);
    chk("t5_bwen", bus0.bank_wen_o[1], 1'b0);
    chk("t5_badd", bus0.bank_add_o[1*BAW +: BAW], 15'h800);
    chk("t5_bwdata", bus0.bank_wdata_o[1*32 +: 32], 32'hA5A5_A5A5);
    tick();
    set_m(0, 3, 1'b1, 32'h0001_0004, 1'b1, 32'h0, 4'hF, 32'h1122_A5A5);
    expect_gnt(0, 6'b001000);
    tick();
    idle(0);
    set_m(1, 0, 1'b1, 32'h08, 1'b1, 32'h0, 4'hF, 32'hCAFE_0002);
    set_m(1, 2, 1'b1, 32'h08, 1'b1, 32'h0, 4'hF, 32'hCAFE_0002);
    expect_gnt(1, 6'b000001); tick();
    expect_gnt(1, 6'b000001); tick();
    expect_gnt(1, 6'b000001); tick();
    set_m(1, 0, 1'b0, 32'h08, 1'b1, 32'h0, 4'hF, 32'h0);
    expect_gnt(1, 6'b000100); tick();
    idle(1);
    set_m(0, 2, 1'b1, 32'h0, 1'b1, 32'h0, 4'hF, 32'hB0B0_0000);
    expect_gnt(0, 6'b000100);
    tick();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) for (int m = 0; m < NM; m++) sq[d][m].delete();
    idle(0);
    expect_gnt(0, 6'b000000);
    chk("t6_rvalid", bus0.mst_r_valid_o, 0);
    chk("t6_rdata", |bus0.mst_r_rdata_o, 0);
    #2 rst_n = 1'b1;
    tick();
    set_m(0, 1, 1'b1, 32'h10, 1'b1, 32'h0, 4'hF, 32'hB0B0_0004);
    set_m(0, 3, 1'b1, 32'h10, 1'b1, 32'h0, 4'hF, 32'hB0B0_0004);
    set_m(0, 5, 1'b1, 32'h10, 1'b1, 32'h0, 4'hF, 32'hB0B0_0004);
    expect_gnt(0, 6'b000010);
    tick();
    idle(0);
    expect_gnt(0, 6'b000000); tick();
    expect_gnt(0, 6'b000000); tick();
    for (int d = 0; d < 2; d++) for (int m = 0; m < NM; m++) chk($sformatf("left%0d_%0d", d, m), sq[d][m].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_tcdm_interleaved_xbar.md
Name: l2_tcdm_interleaved_xbar

Overview:
- Parametrised, word-interleaved crossbar from NB_MASTERS 32-bit TCDM request ports to NB_BANKS single-ported L2 SRAM banks.
- Successor to the fixed 4-port AXI-bridge plus 2-port uDMA L2 interconnect.
- Generalised in master count, bank count and bank depth.
- Adds a selectable per-bank arbitration mode (round-robin or fixed priority) and registered response routing.
- Sits between the axi2tcdm/uDMA TCDM channels and the L2 bank macros in the host domain.

Parameters:
NB_MASTERS, 6, number of TCDM request ports (>=1)
NB_BANKS, 8, number of L2 banks; power of two, >=2
ADDR_WIDTH, 32, master byte-address width
DATA_WIDTH, 32, data width; fixed 32 (byte-enable width = DATA_WIDTH/8)
BANK_ADDR_WIDTH, 15, word-address width per bank
ARB_MODE, 0, 0 = round-robin per bank, 1 = fixed priority (lowest master index wins)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mst_req_i  in  NB_MASTERS  request per master
mst_add_i  in  NB_MASTERS*ADDR_WIDTH  byte address per master
mst_wen_i  in  NB_MASTERS  1 = read, 0 = write
mst_wdata_i  in  NB_MASTERS*DATA_WIDTH  write data
mst_be_i  in  NB_MASTERS*4  byte enables
mst_gnt_o  out  NB_MASTERS  grant, combinational
mst_r_valid_o  out  NB_MASTERS  response valid, 1 cycle after grant
mst_r_rdata_o  out  NB_MASTERS*DATA_WIDTH  read data
bank_req_o  out  NB_BANKS  bank chip-select
bank_add_o  out  NB_BANKS*BANK_ADDR_WIDTH  bank word address
bank_wen_o  out  NB_BANKS  1 = read, 0 = write
bank_wdata_o  out  NB_BANKS*DATA_WIDTH  bank write data
bank_be_o  out  NB_BANKS*4  bank byte enables
bank_rdata_i  in  NB_BANKS*DATA_WIDTH  bank read data, valid 1 cycle after bank_req_o

Behaviour:
- Clock/reset: single clock clk_i. Asynchronous active-low reset rst_ni.
- Address decode, with LB = log2(NB_BANKS):
  - bank = add[2 +: LB]
  - row = add[2+LB +: BANK_ADDR_WIDTH]
  - add[1:0] and bits above the row field are ignored, so the address wraps modulo the L2 size.
- Arbitration: per bank, independent; combinational within the cycle.
  - ARB_MODE 0:
    - Per-bank pointer rr_q[b] (width log2(NB_MASTERS), min 1).
    - Winner = first requesting master at index >= rr_q[b], wrapping past NB_MASTERS-1 to 0.
    - On grant, rr_q[b] <= winner+1, wrapping NB_MASTERS-1 -> 0.
    - Pointer unchanged when there is no request.
  - ARB_MODE 1: lowest requesting index wins; no state.
- Grant:
  - mst_gnt_o[m] = 1 iff mst_req_i[m] and m is the winner for its decoded bank.
  - At most one grant per bank per cycle; masters targeting different banks are all granted in the same cycle.
  - A non-granted master must hold req and all request fields stable until granted. The block neither checks nor buffers this.
- Bank drive:
  - bank_req_o[b] = 1 iff some master is granted to b; the winner's row, wen, wdata and be are forwarded.
  - Idle bank: add, wdata and be driven 0; wen driven 1.
- Response:
  - On grant, register r_pending_q[m] <= 1 and r_bank_q[m] <= bank; otherwise r_pending_q[m] <= 0.
  - mst_r_valid_o[m] = r_pending_q[m], asserted for both reads and writes, exactly 1 cycle after gnt.
  - mst_r_rdata_o[m] = bank_rdata_i[r_bank_q[m]] when r_pending_q[m], else 0. For writes the value is don't-care.
- Throughput: back-to-back grants to one master are allowed every cycle; a response and a new grant can coincide.
- Reset values:
  - r_pending_q = 0, r_bank_q = 0, rr_q = 0.
  - mst_r_valid_o = 0, mst_r_rdata_o = 0.
  - gnt and bank outputs follow inputs combinationally; with no requests, all 0 (bank_wen_o = 1).
- Reset mid-operation: outstanding responses are dropped (r_valid never asserted) and pointers return to 0.
- Boundary cases:
  - NB_MASTERS = 1: arbitration degenerates to pass-through.
  - All masters on one bank: one grant per cycle; in ARB_MODE 0 each master is served within NB_MASTERS cycles.
  - Simultaneous read and write to the same bank: arbitrated like any other conflict.

Test Plan:
- Single access: master 0 read addr 0x0000_000C, bank 3 preloaded 0xDEAD_BEEF at row 0 -> gnt same cycle; bank_req_o[3]=1, bank_add_o[3]=0; next cycle r_valid=1, rdata=0xDEADBEEF.
- Parallel: masters 0..5 read addrs 0x00,0x04,...,0x14 (banks 0..5) in one cycle -> all six gnt=1; all six r_valid=1 next cycle with correct per-bank data.
- RR conflict, ARB_MODE 0: masters 1 and 4 both hold req to addr 0x20 (bank 0) -> grant order 1,4,1,4 over 4 cycles; pointer wraps 5->0 on a grant to master 5.
- Fixed priority, ARB_MODE 1: masters 0 and 2 continuously request bank 2 -> master 0 granted every cycle; master 2 granted only after master 0 drops req.
- Write then read: master 3 writes 0xA5A5_A5A5 with be=4'b0011 to 0x1_0004, then reads it -> bank_be_o=0011 on the write; r_valid for both; read returns the merged bytes from the bank model.
- Reset mid-flight: assert rst_ni=0 in the cycle after a grant -> r_valid stays 0; after release the RR pointers are 0 and the first conflict is granted to the lowest requesting index.
